// File: rtl/wb_master_bridge.sv
// ============================================================================
// Module      : wb_master_bridge
// Description : Single-outstanding request/response to Wishbone classic
//               initiator bridge. Optional bus timeout: WB_MASTER_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_master_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic        req_we_i,
    input  logic [3:0]  req_sel_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic [31:0] wb_addr_o,
    output logic [31:0] wb_data_o,
    output logic        wb_we_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_stb_o,
    output logic        wb_cyc_o,
    input  logic [31:0] wb_data_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUS  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        we_q, we_d;
    logic [3:0]  sel_q, sel_d;
    logic        cyc_q, cyc_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        tmo_hit;

`ifdef WB_MASTER_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] tmo_cnt_q, tmo_cnt_d;
    // Counter holds the number of completed unacknowledged BUS cycles.
    assign tmo_hit = (tmo_cnt_q == TMO_LAST);
`else
    logic [31:0] timeout_cfg_unused;
    assign timeout_cfg_unused = TIMEOUT_CYCLES;
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        we_d        = we_q;
        sel_d       = sel_q;
        cyc_d       = cyc_q;
        rsp_valid_d = rsp_valid_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
`ifdef WB_MASTER_TIMEOUT_EN
        tmo_cnt_d   = tmo_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    addr_d  = req_addr_i;
                    wdata_d = req_wdata_i;
                    we_d    = req_we_i;
                    sel_d   = req_sel_i;
                    cyc_d   = 1'b1;
                    state_d = ST_BUS;
`ifdef WB_MASTER_TIMEOUT_EN
                    tmo_cnt_d = 16'd0;
`endif
                end
            end
            ST_BUS: begin
                // Error outranks ack, and either outranks a coincident timeout.
                if (wb_err_i || (!wb_ack_i && tmo_hit)) begin
                    rdata_d     = 32'd0;
                    err_d       = 1'b1;
                    cyc_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end else if (wb_ack_i) begin
                    rdata_d     = wb_data_i;
                    err_d       = 1'b0;
                    cyc_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end else begin
`ifdef WB_MASTER_TIMEOUT_EN
                    tmo_cnt_d = tmo_cnt_q + 16'd1;
`endif
                end
            end
            ST_RESP: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                cyc_d       = 1'b0;
                rsp_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            we_q        <= 1'b0;
            sel_q       <= 4'd0;
            cyc_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= 32'd0;
            err_q       <= 1'b0;
`ifdef WB_MASTER_TIMEOUT_EN
            tmo_cnt_q   <= 16'd0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            sel_q       <= sel_d;
            cyc_q       <= cyc_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
`ifdef WB_MASTER_TIMEOUT_EN
            tmo_cnt_q   <= tmo_cnt_d;
`endif
        end
    end

    assign req_ready_o = (state_q == ST_IDLE);
    assign wb_addr_o   = addr_q;
    assign wb_data_o   = wdata_q;
    assign wb_we_o     = we_q;
    assign wb_sel_o    = sel_q;
    assign wb_cyc_o    = cyc_q;
    assign wb_stb_o    = cyc_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rdata_q;
    assign rsp_err_o   = err_q;

endmodule

`default_nettype wire

// File: doc/wb_master_bridge.md
WB_MASTER_BRIDGE -- requirements
Module: wb_master_bridge

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 255, bus-cycle count after which an unacknowledged transfer is aborted (legal range 1..65535).
REQ-002 clk_i  in  1  clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 req_valid_i  in  1  request present; req_ready_o  out  1  bridge accepts request.
REQ-005 req_addr_i  in  32  byte address; req_wdata_i  in  32  write data; req_we_i  in  1  1=write; req_sel_i  in  4  byte lanes.
REQ-006 rsp_valid_o  out  1  response present; rsp_ready_i  in  1  consumer takes response.
REQ-007 rsp_rdata_o  out  32  read data; rsp_err_o  out  1  bus error or timeout.
REQ-008 wb_addr_o  out  32; wb_data_o  out  32; wb_we_o  out  1; wb_sel_o  out  4; wb_stb_o  out  1; wb_cyc_o  out  1  Wishbone classic initiator outputs.
REQ-009 wb_data_i  in  32; wb_ack_i  in  1; wb_err_i  in  1  Wishbone responder inputs.

Function
REQ-010 FSM states SHALL be IDLE, BUS, RESP; all Wishbone and response outputs driven from registers.
REQ-011 IDLE: req_ready_o=1; handshake (req_valid_i && req_ready_o) SHALL latch addr/wdata/we/sel into wb_*_o and enter BUS next edge.
REQ-012 req_ready_o SHALL be 0 in BUS and RESP; at most one outstanding transfer.
REQ-013 BUS: wb_cyc_o=wb_stb_o=1; wb_addr_o, wb_data_o, wb_we_o, wb_sel_o SHALL hold stable until the cycle ends.
REQ-014 BUS with wb_ack_i=1 and wb_err_i=0: capture wb_data_i into rsp_rdata_o (writes capture it too, ignored), rsp_err_o=0, enter RESP, drop cyc/stb on same edge.
REQ-015 BUS with wb_err_i=1 (ack value irrelevant, err wins): rsp_rdata_o=0, rsp_err_o=1, enter RESP, drop cyc/stb.
REQ-016 wb_cyc_o/wb_stb_o SHALL be low for at least one full cycle between consecutive transfers (guaranteed by RESP).
REQ-017 RESP: rsp_valid_o=1; rsp_rdata_o/rsp_err_o stable until rsp_valid_o && rsp_ready_i, then IDLE next edge.
REQ-018 Latency: request accepted at edge 0 -> stb high cycle 1; ack sampled at edge N -> rsp_valid_o high from cycle N+1; zero-wait responder (ack cycle 1) gives rsp_valid_o in cycle 2.
REQ-019 wb_ack_i/wb_err_i in IDLE or RESP SHALL be ignored.
REQ-020 req_valid_i dropping without handshake SHALL have no effect.

Reset
REQ-021 rst asserted SHALL immediately force IDLE, wb_cyc_o=wb_stb_o=wb_we_o=0, wb_addr_o=wb_data_o=0, wb_sel_o=0, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, timeout counter=0.
REQ-022 Reset mid-BUS or mid-RESP SHALL abandon the transfer; no response is produced after release.
REQ-023 First request is accepted on the first rising edge after rst deasserts (req_ready_o=1 from reset).

Configuration
REQ-024 Macro WB_MASTER_TIMEOUT_EN defined: a 16-bit counter cleared on entering BUS, incremented each BUS cycle without ack/err; reaching TIMEOUT_CYCLES SHALL end the cycle as in REQ-015 (rsp_err_o=1, rdata=0).
REQ-025 ack/err on the same edge the counter reaches TIMEOUT_CYCLES SHALL take priority over timeout.
REQ-026 Macro undefined: no counter is synthesised; BUS waits indefinitely for wb_ack_i or wb_err_i.

Verification
REQ-027 Write 0xA5A5_0001 to 0x0000_0004, sel=0xF, responder acks cycle after stb -> wb_* show addr 0x4, data 0xA5A5_0001, we=1 for one stb cycle; rsp_valid_o cycle 2, rsp_err_o=0.
REQ-028 Read 0x0000_0008, responder inserts 3 wait states then acks with 0x1234_5678 -> stb high 4 cycles, rsp_rdata_o=0x1234_5678, rsp_err_o=0.
REQ-029 Read with wb_err_i=1 and wb_ack_i=1 same cycle -> rsp_err_o=1, rsp_rdata_o=0.
REQ-030 WB_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> stb high exactly 4 cycles, rsp_err_o=1; undefined -> stb held 100 cycles, no response.
REQ-031 rsp_ready_i held low 5 cycles -> rsp_valid_o and data stable 5 cycles, req_ready_o=0 throughout, new request accepted the cycle after handshake.
REQ-032 rst pulsed while stb high -> cyc/stb fall asynchronously, rsp_valid_o never asserts, next request completes normally.
